// File: rtl/down_counter.sv
// Prescaled, loadable down-counter/timer with start/busy/done handshake and optional auto-reload.
// Latency: done is high in the cycle after edge E0+(P+1)*L, where E0 is the accepting start edge.
// Backpressure: none; start is sampled only in IDLE, stop aborts RUN, and all outputs are registered.
module down_counter #(
  parameter int WIDTH           = 5,
  parameter int PRESCALER_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PRESCALER_WIDTH-1:0] prescaler,
  input  logic [WIDTH-1:0]           load_value,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       auto_reload,
  output logic [WIDTH-1:0]           counter_out,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state, state_nxt;
  logic [WIDTH-1:0]           count, count_nxt;
  logic [WIDTH-1:0]           l_lat, l_lat_nxt;
  logic [PRESCALER_WIDTH-1:0] pc, pc_nxt;
  logic [PRESCALER_WIDTH-1:0] p_lat, p_lat_nxt;
  logic                       done_r, done_nxt;

  // State register: every piece of timer state, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      l_lat  <= '0;
      pc     <= '0;
      p_lat  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      l_lat  <= l_lat_nxt;
      pc     <= pc_nxt;
      p_lat  <= p_lat_nxt;
      done_r <= done_nxt;
    end
  end

  // Next-state logic: arm on start in IDLE; in RUN, stop beats a tick, and the
  // prescale counter wraps by equality so even an all-ones divide never overflows.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    l_lat_nxt = l_lat;
    pc_nxt    = pc;
    p_lat_nxt = p_lat;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (load_value != '0) begin
            p_lat_nxt = prescaler;
            l_lat_nxt = load_value;
            count_nxt = load_value;
            pc_nxt    = '0;
            state_nxt = RUN;
          end else begin
            // A zero-length timer completes at once without ever going busy.
            count_nxt = '0;
            done_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          // Abort freezes the visible count so software can read where it stopped.
          state_nxt = IDLE;
          pc_nxt    = '0;
        end else if (pc == p_lat) begin
          pc_nxt = '0;
          if (count > WIDTH'(1)) begin
            count_nxt = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            done_nxt = 1'b1;
            if (auto_reload) begin
              count_nxt = l_lat;
            end else begin
              count_nxt = '0;
              state_nxt = IDLE;
            end
          end else begin
            // Unreachable in normal operation; never step below zero.
            state_nxt = IDLE;
          end
        end else begin
          pc_nxt = pc + PRESCALER_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign counter_out = count;
  assign busy        = (state == RUN);
  assign done        = done_r;

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] prescaler;
  logic [4:0]  load_value;
  logic        start, stop, auto_reload;
  logic [4:0]  counter_out;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  down_counter #(.WIDTH(5), .PRESCALER_WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .prescaler   (prescaler),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .counter_out (counter_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Reference model: elapsed clocks since arming, count derived by division.
  bit              m_run;
  longint unsigned m_t, m_p, m_l;
  int              m_cnt;
  bit              m_done;

  task automatic model_reset();
    m_run = 0; m_t = 0; m_p = 0; m_l = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_update();
    m_done = 0;
    if (!m_run) begin
      if (start) begin
        if (load_value != 0) begin
          m_run = 1; m_p = prescaler; m_l = load_value; m_t = 0; m_cnt = load_value;
        end else begin
          m_cnt = 0; m_done = 1;
        end
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      m_t++;
      if (m_t == (m_p + 1) * m_l) begin
        m_done = 1;
        if (auto_reload) begin
          m_t = 0; m_cnt = int'(m_l);
        end else begin
          m_run = 0; m_cnt = 0;
        end
      end else begin
        m_cnt = int'(m_l - m_t / (m_p + 1));
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    chk("model_cnt", counter_out, m_cnt);
    chk("model_busy", busy, m_run);
    chk("model_done", done, m_done);
  endtask

  typedef struct {
    logic        st, sp, ar;
    logic [31:0] p;
    logic [4:0]  l;
    logic [4:0]  ec;
    logic        eb, ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic ar, input logic [31:0] p,
                              input logic [4:0] l, input logic [4:0] ec, input logic eb, input logic ed);
    vec_t v;
    v.st = st; v.sp = sp; v.ar = ar; v.p = p; v.l = l; v.ec = ec; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  initial begin
    bit hit;
    model_reset();
    reset = 1'b1; prescaler = 0; load_value = 5; start = 1'b1; stop = 0; auto_reload = 0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("rst_cnt", counter_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 0;
    reset = 1'b0;

    // L=5,P=0 countdown, L=0 immediate done, stop freeze, start+stop in IDLE.
    tbl.push_back(mk(1, 0, 0, 0,  5, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  5, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  5, 3, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,  9, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  5, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  5, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  5, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 10, 10, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 10, 9, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 10, 8, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 10, 7, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 10, 6, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 10, 6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 10, 6, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  2, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; stop = tbl[i].sp; auto_reload = tbl[i].ar;
      prescaler = tbl[i].p; load_value = tbl[i].l;
      step();
      chk($sformatf("tbl%0d_cnt", i), counter_out, tbl[i].ec);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
    end
    start = 0; stop = 0;

    // L=3,P=3 one-shot: each value held 4 clocks, done 12 clocks after start.
    start = 1; load_value = 3; prescaler = 3; auto_reload = 0;
    step();
    start = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("p3_cnt", counter_out, (k == 12) ? 0 : 3 - k / 4);
      chk("p3_done", done, (k == 12) ? 1 : 0);
      chk("p3_busy", busy, (k == 12) ? 0 : 1);
    end

    // L=4,P=1 auto-reload: done every 8 clocks; clearing auto_reload ends at the next terminal.
    start = 1; load_value = 4; prescaler = 1; auto_reload = 1;
    step();
    start = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 25) auto_reload = 0;
      step();
      chk("ar_done", done, (k % 8 == 0) ? 1 : 0);
      if (k < 32) chk("ar_nonzero", (counter_out != 0) ? 1 : 0, 1);
    end
    chk("ar_end_cnt", counter_out, 0);
    chk("ar_end_busy", busy, 0);

    // Prescaler and load changes during RUN are ignored until the next start.
    start = 1; load_value = 3; prescaler = 2;
    step();
    start = 0; prescaler = 0; load_value = 9;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("pchg_done", done, (k == 9) ? 1 : 0);
    end

    // Maximum prescaler: no tick for a long time, and pc must not wrap early.
    start = 1; load_value = 1; prescaler = 32'hFFFF_FFFF;
    step();
    start = 0;
    repeat (10) step();
    chk("pmax_cnt", counter_out, 1);
    chk("pmax_busy", busy, 1);
    stop = 1;
    step();
    stop = 0;
    chk("pmax_stop_busy", busy, 0);

    // Asynchronous reset mid-run at counter_out=3, between clock edges.
    start = 1; load_value = 5; prescaler = 0;
    step();
    start = 0;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (counter_out == 3) hit = 1;
      else step();
    end
    chk("arst_reached3", hit, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt", counter_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // Randomised traffic against the reference model.
    for (int k = 0; k < 1500; k++) begin
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      auto_reload = $urandom_range(0, 1);
      prescaler   = $urandom_range(0, 3);
      load_value  = 5'($urandom_range(0, 6));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
